// File: rtl/network_stream_bridge.sv
// network_stream_bridge
//   Packs NUM_INPUTS stream samples into the network input vector, fires a
//   one-cycle input-valid, waits for the network result, then replays the
//   NUM_OUTPUTS result values on a valid/ready master stream (LSB slot first).
//
//   Ports
//     CLK, RSTN        clock (rising edge), async active-low reset
//     S_DATA/VALID/READY   sample slave stream
//     NET_VALUES_OUT   packed sample vector to network (held until next LOAD)
//     NET_VALID_OUT    one-cycle fire pulse
//     NET_VALUES_IN    network result vector
//     NET_VALID_IN     network result valid pulse (honoured only in WAIT)
//     M_DATA/VALID/READY/LAST  result master stream
//     BUSY             high in every state except LOAD
//     TIMEOUT_ERR      sticky WAIT watchdog flag
//
//   Optional: define NET_TIMEOUT_EN to build the WAIT watchdog
//   (TIMEOUT_CYCLES). Without it WAIT blocks forever and TIMEOUT_ERR is 0.
module network_stream_bridge #(
  parameter int NUM_INPUTS     = 9,
  parameter int NUM_OUTPUTS    = 3,
  parameter int WIDTH          = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                         CLK,
  input  logic                         RSTN,
  input  logic [WIDTH-1:0]             S_DATA,
  input  logic                         S_VALID,
  output logic                         S_READY,
  output logic [NUM_INPUTS*WIDTH-1:0]  NET_VALUES_OUT,
  output logic                         NET_VALID_OUT,
  input  logic [NUM_OUTPUTS*WIDTH-1:0] NET_VALUES_IN,
  input  logic                         NET_VALID_IN,
  output logic [WIDTH-1:0]             M_DATA,
  output logic                         M_VALID,
  input  logic                         M_READY,
  output logic                         M_LAST,
  output logic                         BUSY,
  output logic                         TIMEOUT_ERR
);
  localparam int IW = (NUM_INPUTS  > 1) ? $clog2(NUM_INPUTS)  : 1;
  localparam int RW = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;

  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_FIRE, ST_WAIT, ST_DRAIN} state_t;

  state_t                         state;
  logic [IW-1:0]                  idx;
  logic [RW-1:0]                  ridx;
  logic [NUM_OUTPUTS*WIDTH-1:0]   result;
  logic [RW-1:0]                  ridx_nxt;
  logic                           ridx_last;

  assign ridx_nxt  = ridx + RW'(1);
  assign ridx_last = (ridx == RW'(NUM_OUTPUTS-1));
  assign BUSY      = (state != ST_LOAD);

`ifdef NET_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] wcnt;
  logic          timeout_err;
  assign TIMEOUT_ERR = timeout_err;
`else
  assign TIMEOUT_ERR = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state          <= ST_IDLE;
      idx            <= '0;
      ridx           <= '0;
      result         <= '0;
      NET_VALUES_OUT <= '0;
      S_READY        <= 1'b0;
      NET_VALID_OUT  <= 1'b0;
      M_VALID        <= 1'b0;
      M_LAST         <= 1'b0;
      M_DATA         <= '0;
`ifdef NET_TIMEOUT_EN
      wcnt           <= '0;
      timeout_err    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          state   <= ST_LOAD;
          S_READY <= 1'b1;
        end
        ST_LOAD: begin
          if (S_VALID && S_READY) begin
            NET_VALUES_OUT[int'(idx)*WIDTH +: WIDTH] <= S_DATA;
            if (idx == IW'(NUM_INPUTS-1)) begin
              idx           <= '0;
              state         <= ST_FIRE;
              S_READY       <= 1'b0;
              NET_VALID_OUT <= 1'b1;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        ST_FIRE: begin
          NET_VALID_OUT <= 1'b0;
          state         <= ST_WAIT;
`ifdef NET_TIMEOUT_EN
          wcnt          <= '0;
`endif
        end
        ST_WAIT: begin
          // A result arriving on the watchdog limit cycle still wins.
          if (NET_VALID_IN) begin
            result  <= NET_VALUES_IN;
            ridx    <= '0;
            M_VALID <= 1'b1;
            M_DATA  <= NET_VALUES_IN[WIDTH-1:0];
            M_LAST  <= (NUM_OUTPUTS == 1);
            state   <= ST_DRAIN;
`ifdef NET_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
          end
`ifdef NET_TIMEOUT_EN
          else if (wcnt == TW'(TIMEOUT_CYCLES-1)) begin
            timeout_err <= 1'b1;
            state       <= ST_LOAD;
            S_READY     <= 1'b1;
          end else begin
            wcnt <= wcnt + TW'(1);
          end
`endif
        end
        ST_DRAIN: begin
          if (M_READY) begin
            if (ridx_last) begin
              ridx    <= '0;
              M_VALID <= 1'b0;
              M_LAST  <= 1'b0;
              S_READY <= 1'b1;
              state   <= ST_LOAD;
            end else begin
              ridx   <= ridx_nxt;
              M_DATA <= result[int'(ridx_nxt)*WIDTH +: WIDTH];
              M_LAST <= (ridx_nxt == RW'(NUM_OUTPUTS-1));
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_network_stream_bridge.sv
module tb_network_stream_bridge;
  localparam int NI = 9, NO = 3, W = 8;

  logic            CLK = 0;
  logic            RSTN = 0;
  logic [W-1:0]    S_DATA = '0;
  logic            S_VALID = 0;
  logic            S_READY;
  logic [NI*W-1:0] NET_VALUES_OUT;
  logic            NET_VALID_OUT;
  logic [NO*W-1:0] NET_VALUES_IN = '0;
  logic            NET_VALID_IN = 0;
  logic [W-1:0]    M_DATA;
  logic            M_VALID;
  logic            M_READY = 0;
  logic            M_LAST;
  logic            BUSY;
  logic            TIMEOUT_ERR;

  int errs = 0, checks = 0;

  network_stream_bridge #(.NUM_INPUTS(NI), .NUM_OUTPUTS(NO), .WIDTH(W), .TIMEOUT_CYCLES(8)) dut (
    .CLK(CLK), .RSTN(RSTN), .S_DATA(S_DATA), .S_VALID(S_VALID), .S_READY(S_READY),
    .NET_VALUES_OUT(NET_VALUES_OUT), .NET_VALID_OUT(NET_VALID_OUT),
    .NET_VALUES_IN(NET_VALUES_IN), .NET_VALID_IN(NET_VALID_IN),
    .M_DATA(M_DATA), .M_VALID(M_VALID), .M_READY(M_READY), .M_LAST(M_LAST),
    .BUSY(BUSY), .TIMEOUT_ERR(TIMEOUT_ERR));

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  // Stream 9 samples (slot k = vec[k*8 +: 8]); optionally inject a stray
  // NET_VALID_IN pulse after 'stray_at' samples. Leaves the bench in WAIT.
  task automatic load9(input logic [71:0] vec, input int stray_at);
    for (int i = 0; i < NI; i++) begin
      if (i == stray_at) begin
        S_VALID = 0; NET_VALID_IN = 1; NET_VALUES_IN = 24'hAAAAAA;
        tick();
        NET_VALID_IN = 0;
        chk("stray_no_mvalid", M_VALID, 0);
        chk("stray_still_load", S_READY, 1);
      end
      chk("load_ready", S_READY, 1);
      S_VALID = 1; S_DATA = vec[i*8 +: 8];
      tick();
      if (i == NI-2) chk("no_early_fire", NET_VALID_OUT, 0);
    end
    S_VALID = 0; S_DATA = 8'hFF;
    chk("fire_pulse", NET_VALID_OUT, 1);
    chk("fire_vec", NET_VALUES_OUT, vec);
    chk("fire_not_ready", S_READY, 0);
    chk("fire_busy", BUSY, 1);
    tick();
    chk("wait_pulse_gone", NET_VALID_OUT, 0);
    chk("wait_not_ready", S_READY, 0);
    chk("wait_no_mvalid", M_VALID, 0);
    chk("wait_vec_held", NET_VALUES_OUT, vec);
  endtask

  task automatic respond(input logic [23:0] res);
    NET_VALUES_IN = res; NET_VALID_IN = 1;
    tick();
    NET_VALID_IN = 0; NET_VALUES_IN = '0;
    chk("capture_mvalid", M_VALID, 1);
  endtask

  // Drive M_READY from pat[c] each cycle and score handshakes against res.
  task automatic drain(input logic [7:0] pat, input int ncyc, input logic [23:0] res);
    int n = 0;
    for (int c = 0; c < ncyc; c++) begin
      M_READY = pat[c];
      chk("drain_valid", M_VALID, 1);
      if (n < NO) begin
        chk("drain_data", M_DATA, res[n*8 +: 8]);
        chk("drain_last", M_LAST, (n == NO-1));
      end
      if (M_VALID && M_READY) n++;
      tick();
    end
    M_READY = 0;
    chk("drain_count", n, NO);
    chk("drain_done_mvalid", M_VALID, 0);
    chk("drain_done_ready", S_READY, 1);
    chk("drain_done_busy", BUSY, 0);
  endtask

  initial begin
    #1;
    chk("rst_s_ready", S_READY, 0);
    chk("rst_net_valid", NET_VALID_OUT, 0);
    chk("rst_m_valid", M_VALID, 0);
    chk("rst_m_last", M_LAST, 0);
    chk("rst_m_data", M_DATA, 0);
    chk("rst_net_values", NET_VALUES_OUT, 0);
    chk("rst_busy", BUSY, 1);
    chk("rst_terr", TIMEOUT_ERR, 0);
    tick(); tick();
    RSTN = 1;
    tick();
    chk("idle_to_load", S_READY, 1);

    // Basic inference, M_READY held high.
    load9(72'h20E020E020E020E020, -1);
    respond(24'h20E020);
    drain(8'hFF, 3, 24'h20E020);

    // Backpressure pattern 0,1,0,0,1,1.
    load9(72'h090807060504030201, -1);
    respond(24'h563412);
    drain(8'b110010, 6, 24'h563412);

    // Stray NET_VALID_IN during LOAD is ignored.
    load9(72'h181716151413121110, 4);
    respond(24'h332211);
    drain(8'hFF, 3, 24'h332211);

    // Reset in DRAIN after one handshake.
    load9(72'h0102030405060708A5, -1);
    respond(24'h665544);
    M_READY = 1;
    tick();
    M_READY = 0;
    chk("pre_rst_data", M_DATA, 8'h55);
    RSTN = 0; #1;
    chk("arst_m_valid", M_VALID, 0);
    chk("arst_m_data", M_DATA, 0);
    chk("arst_m_last", M_LAST, 0);
    chk("arst_s_ready", S_READY, 0);
    chk("arst_net_values", NET_VALUES_OUT, 0);
    chk("arst_busy", BUSY, 1);
    tick();
    RSTN = 1; M_READY = 1;
    tick();
    chk("post_rst_mvalid1", M_VALID, 0);
    tick();
    chk("post_rst_mvalid2", M_VALID, 0);
    chk("post_rst_ready", S_READY, 1);
    M_READY = 0;

`ifdef NET_TIMEOUT_EN
    load9(72'h112233445566778899, -1);
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk("to_not_yet", TIMEOUT_ERR, 0);
    end
    tick();
    chk("to_err", TIMEOUT_ERR, 1);
    chk("to_no_mvalid", M_VALID, 0);
    chk("to_ready", S_READY, 1);
    chk("to_vec_kept", NET_VALUES_OUT, 72'h112233445566778899);
    load9(72'h0F0E0D0C0B0A090807, -1);
    chk("to_sticky", TIMEOUT_ERR, 1);
    respond(24'hC3B2A1);
    chk("to_cleared", TIMEOUT_ERR, 0);
    drain(8'hFF, 3, 24'hC3B2A1);
`else
    load9(72'h112233445566778899, -1);
    for (int k = 0; k < 20; k++) tick();
    chk("nowd_still_wait", M_VALID, 0);
    chk("nowd_not_ready", S_READY, 0);
    chk("nowd_terr", TIMEOUT_ERR, 0);
    respond(24'hC3B2A1);
    drain(8'hFF, 3, 24'hC3B2A1);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
